fetch_ctrl: RTL and testbench

Instruction-fetch sequencer placed between the branch predictor, the synchronous instruction ROM block and the decode stage. It owns the word-addressed fetch PC and issues one ROM read per cycle. It absorbs the ROM's one-cycle read latency in a 2-entry instruction queue, so decode stalls never lose an instruction. It applies predictor hits and misprediction redirects, and supports a halt/drain state for ecall/ebreak.

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the fetch PC, issues one ROM read per cycle,
// buffers responses in a 2-entry queue and handles predictor hits, redirects and halt/drain.
module fetch_ctrl #(
    parameter int             PCW     = 13,
    parameter logic [PCW-1:0] STARTPC = {PCW{1'b0}}
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic [PCW-1:0] prepc,
    input  logic           hit_predict,
    input  logic [PCW-1:0] nextpc,
    input  logic           fail_predict,
    input  logic           stall,
    input  logic           halt_req,
    output logic           mem_en,
    output logic [PCW-1:0] mem_addr,
    input  logic [31:0]    mem_rdata,
    output logic           out_valid,
    output logic [PCW-1:0] out_pc,
    output logic [31:0]    out_inst,
    output logic           halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [PCW-1:0] fpc_q, fpc_d;
    logic           infl_q;
    logic [PCW-1:0] infl_pc_q;
    logic [1:0]     cnt_q, cnt_d;
    logic           head_q, head_d;
    logic [PCW-1:0] fifo_pc_q   [2];
    logic [31:0]    fifo_inst_q [2];

    logic           pop_s, push_s, room_s, issue_s, wr_idx_s;
    logic [2:0]     occ_s;
    logic [PCW-1:0] addr_s;

    assign out_valid = (cnt_q != 2'd0);
    assign out_pc    = fifo_pc_q[head_q];
    assign out_inst  = fifo_inst_q[head_q];
    assign halted    = (state_q == ST_HALT);

    // The read strobe is masked while reset is held so the ROM sees no request during reset.
    assign mem_en    = issue_s & NRST;
    assign mem_addr  = mem_en ? addr_s : fpc_q;

    // Next-state, issue decision and queue bookkeeping.
    always_comb begin
        pop_s    = out_valid & ~stall;
        push_s   = infl_q & ~fail_predict;
        occ_s    = {1'b0, cnt_q} + {2'b00, infl_q};
        room_s   = (occ_s < (3'd2 + {2'b00, pop_s}));
        wr_idx_s = head_q ^ cnt_q[0];
        issue_s  = 1'b0;
        addr_s   = fpc_q;
        state_d  = state_q;
        fpc_d    = fpc_q;
        cnt_d    = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        head_d   = head_q ^ pop_s;

        if (fail_predict) begin
            issue_s = 1'b1;
            addr_s  = nextpc;
            state_d = ST_RUN;
            cnt_d   = 2'd0;
            head_d  = head_q;
            fpc_d   = hit_predict ? prepc : (nextpc + PC_ONE);
        end else if (halt_req) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    issue_s = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    issue_s = room_s;
                end
                ST_HALT: begin
                    issue_s = 1'b0;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
            if (issue_s) begin
                fpc_d = hit_predict ? prepc : (fpc_q + PC_ONE);
            end else begin
                fpc_d = fpc_q;
            end
        end
    end

    // State, PC, in-flight tracking and queue storage.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= ST_BOOT;
            fpc_q     <= STARTPC;
            infl_q    <= 1'b0;
            infl_pc_q <= STARTPC;
            cnt_q     <= 2'd0;
            head_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= {PCW{1'b0}};
                fifo_inst_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            infl_q    <= issue_s;
            infl_pc_q <= addr_s;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            if (push_s) begin
                fifo_pc_q[wr_idx_s]   <= infl_pc_q;
                fifo_inst_q[wr_idx_s] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a synchronous ROM model (ROM[i] = i + 0x100).
module tb_fetch_ctrl;

    localparam int PCW = 13;

    logic           CLK = 1'b0;
    logic           NRST;
    logic [PCW-1:0] prepc;
    logic           hit_predict;
    logic [PCW-1:0] nextpc;
    logic           fail_predict;
    logic           stall;
    logic           halt_req;
    logic           mem_en;
    logic [PCW-1:0] mem_addr;
    logic [31:0]    mem_rdata = 32'd0;
    logic           out_valid;
    logic [PCW-1:0] out_pc;
    logic [31:0]    out_inst;
    logic           halted;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.PCW(PCW), .STARTPC(13'd0)) dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .prepc       (prepc),
        .hit_predict (hit_predict),
        .nextpc      (nextpc),
        .fail_predict(fail_predict),
        .stall       (stall),
        .halt_req    (halt_req),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data for the address read this cycle appears next cycle.
    always @(posedge CLK) begin
        if (mem_en) mem_rdata <= 32'(mem_addr) + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_pc"},    32'(out_pc),    32'd0);
        chk({tag, "_out_inst"},  out_inst,       32'd0);
        chk({tag, "_halted"},    32'(halted),    32'd0);
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"},    32'(out_pc),    pc);
        chk({tag, "_inst"},  out_inst,       pc + 32'h100);
    endtask

    initial begin
        NRST = 1'b0; prepc = 13'd0; hit_predict = 1'b0; nextpc = 13'd0;
        fail_predict = 1'b0; stall = 1'b0; halt_req = 1'b0;
        #2;
        chk_reset("rst");

        // BOOT issues address 0, then sequential fetch
        @(negedge CLK); NRST = 1'b1; #1;
        chk("boot_en", 32'(mem_en), 32'd1);
        chk("boot_addr", 32'(mem_addr), 32'd0);
        chk("boot_valid", 32'(out_valid), 32'd0);
        @(negedge CLK); #1;
        chk("s1_addr", 32'(mem_addr), 32'd1);
        chk("s1_valid", 32'(out_valid), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge CLK); #1;
            head("seq", 32'(k - 2));
            chk("seq_addr", 32'(mem_addr), 32'(k));
        end

        // Stall five cycles at out_pc=3
        for (int k = 5; k <= 9; k++) begin
            @(negedge CLK); stall = 1'b1; #1;
            head("stall", 32'd3);
            chk("stall_en", 32'(mem_en), 32'd0);
        end
        @(negedge CLK); stall = 1'b0; #1;
        head("rel0", 32'd3);
        chk("rel_en", 32'(mem_en), 32'd1);
        chk("rel_addr", 32'(mem_addr), 32'd5);
        @(negedge CLK); #1; head("rel1", 32'd4);
        @(negedge CLK); #1; head("rel2", 32'd5);

        // Predictor hit while address 8 is issued
        @(negedge CLK); hit_predict = 1'b1; prepc = 13'h40; #1;
        chk("hit_addr", 32'(mem_addr), 32'd8);
        head("hit_h", 32'd6);
        @(negedge CLK); hit_predict = 1'b0; #1;
        chk("tgt_addr", 32'(mem_addr), 32'h40);
        head("hit_h7", 32'd7);
        @(negedge CLK); #1; head("hit_h8", 32'd8);
        @(negedge CLK); #1; head("hit_h40", 32'h40);

        // Fill queue under stall, then redirect to 0x20
        @(negedge CLK); stall = 1'b1; #1;
        head("fill", 32'h41);
        chk("fill_en", 32'(mem_en), 32'd0);
        @(negedge CLK); fail_predict = 1'b1; nextpc = 13'h20; #1;
        chk("redir_en", 32'(mem_en), 32'd1);
        chk("redir_addr", 32'(mem_addr), 32'h20);
        @(negedge CLK); fail_predict = 1'b0; stall = 1'b0; #1;
        chk("redir_gap", 32'(out_valid), 32'd0);
        chk("redir_next", 32'(mem_addr), 32'h21);
        @(negedge CLK); #1; head("redir_h", 32'h20);

        // Redirect in steady state: in-flight response must be dropped
        @(negedge CLK); fail_predict = 1'b1; nextpc = 13'h30; #1;
        chk("redir2_addr", 32'(mem_addr), 32'h30);
        @(negedge CLK); fail_predict = 1'b0; #1;
        chk("redir2_gap", 32'(out_valid), 32'd0);
        @(negedge CLK); #1; head("redir2_h", 32'h30);

        // Halt: issue stops at once, queue drains
        @(negedge CLK); halt_req = 1'b1; #1;
        head("halt_h", 32'h31);
        chk("halt_en", 32'(mem_en), 32'd0);
        @(negedge CLK); halt_req = 1'b0; #1;
        chk("halted1", 32'(halted), 32'd1);
        chk("halt_en1", 32'(mem_en), 32'd0);
        head("drain", 32'h32);
        @(negedge CLK); #1;
        chk("drained", 32'(out_valid), 32'd0);
        chk("halt_en2", 32'(mem_en), 32'd0);
        @(negedge CLK); fail_predict = 1'b1; nextpc = 13'h10; #1;
        chk("resume_en", 32'(mem_en), 32'd1);
        chk("resume_addr", 32'(mem_addr), 32'h10);
        @(negedge CLK); fail_predict = 1'b0; #1;
        chk("halted0", 32'(halted), 32'd0);
        chk("resume_next", 32'(mem_addr), 32'h11);
        @(negedge CLK); #1; head("resume_h", 32'h10);

        // PC wrap at 2^13
        @(negedge CLK); fail_predict = 1'b1; nextpc = 13'h1FFE; #1;
        chk("wrap0", 32'(mem_addr), 32'h1FFE);
        @(negedge CLK); fail_predict = 1'b0; #1;
        chk("wrap1", 32'(mem_addr), 32'h1FFF);
        @(negedge CLK); #1;
        chk("wrap2", 32'(mem_addr), 32'h0000);
        head("wrap_h0", 32'h1FFE);
        @(negedge CLK); #1; head("wrap_h1", 32'h1FFF);
        @(negedge CLK); #1; head("wrap_h2", 32'h0);

        // Asynchronous reset mid-cycle, then restart from BOOT
        #3; NRST = 1'b0; #1;
        chk_reset("arst");
        @(negedge CLK); NRST = 1'b1; #1;
        chk("reboot_en", 32'(mem_en), 32'd1);
        chk("reboot_addr", 32'(mem_addr), 32'd0);
        @(negedge CLK); #1;
        @(negedge CLK); #1; head("reboot_h", 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
